// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for the EX stage (DIV/DIVU).
// Stalls the pipeline while busy and pulses ready when quotient/remainder are committed.
module div_ctrl #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_div,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          annul,
    output logic          stallreq_for_div,
    output logic          ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    localparam int unsigned CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_raw_q, dvd_raw_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quo_w_q, quo_w_d;
    logic [DW-1:0] prem_q, prem_d;
    logic          sgn_q, sgn_d;
    logic          dneg_q, dneg_d;
    logic          vneg_q, vneg_d;
    logic          ready_q, ready_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [DW-1:0] remainder_q, remainder_d;

    logic [DW:0]   pr_shift;
    logic [DW:0]   trial;
    logic          qbit;
    logic [DW-1:0] pr_iter;
    logic [DW-1:0] q_iter;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_raw_q   <= '0;
            dvs_q       <= '0;
            quo_w_q     <= '0;
            prem_q      <= '0;
            sgn_q       <= 1'b0;
            dneg_q      <= 1'b0;
            vneg_q      <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_raw_q   <= dvd_raw_d;
            dvs_q       <= dvs_d;
            quo_w_q     <= quo_w_d;
            prem_q      <= prem_d;
            sgn_q       <= sgn_d;
            dneg_q      <= dneg_d;
            vneg_q      <= vneg_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_raw_d   = dvd_raw_q;
        dvs_d       = dvs_q;
        quo_w_d     = quo_w_q;
        prem_d      = prem_q;
        sgn_d       = sgn_q;
        dneg_d      = dneg_q;
        vneg_d      = vneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        // One restoring step: shift in the next dividend bit, keep the trial if non-negative.
        pr_shift = {prem_q, quo_w_q[DW-1]};
        trial    = pr_shift - {1'b0, dvs_q};
        qbit     = ~trial[DW];
        pr_iter  = qbit ? trial[DW-1:0] : pr_shift[DW-1:0];
        q_iter   = {quo_w_q[DW-2:0], qbit};

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    dvd_raw_d = dividend;
                    sgn_d     = signed_div;
                    dneg_d    = dividend[DW-1];
                    vneg_d    = divisor[DW-1];
                    quo_w_d   = (signed_div && dividend[DW-1]) ? (~dividend + DW'(1)) : dividend;
                    dvs_d     = (signed_div && divisor[DW-1]) ? (~divisor + DW'(1)) : divisor;
                    prem_d    = '0;
                    cnt_d     = '0;
                    state_d   = (divisor == '0) ? ZERO : RUN;
                end
            end
            ZERO: begin
                if (annul) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = dvd_raw_q;
                end
            end
            RUN: begin
                if (annul) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    quo_w_d = q_iter;
                    prem_d  = pr_iter;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d     = DONE;
                        cnt_d       = '0;
                        quotient_d  = (sgn_q && (dneg_q ^ vneg_q)) ? (~q_iter + DW'(1)) : q_iter;
                        remainder_d = (sgn_q && dneg_q) ? (~pr_iter + DW'(1)) : pr_iter;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == DONE);
    end

    assign stallreq_for_div = ~annul & (((state_q == IDLE) & start) |
                                        (state_q == ZERO) | (state_q == RUN));
    assign ready            = ready_q;
    assign quotient         = quotient_q;
    assign remainder        = remainder_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed DIV/DIVU cases, divide-by-zero, annul,
// mid-operation reset, back-to-back accepts and a few randomised operands.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stallreq_for_div;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_fail;
    int          ready_cnt;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_ctrl #(.DW(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .signed_div       (signed_div),
        .dividend         (dividend),
        .divisor          (divisor),
        .annul            (annul),
        .stallreq_for_div (stallreq_for_div),
        .ready            (ready),
        .quotient         (quotient),
        .remainder        (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ready === 1'b1) ready_cnt = ready_cnt + 1;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Launch one operation at the next negedge and follow it until ready (bounded).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output int stall,
                         output logic [31:0] q, output logic [31:0] r, output bit moved);
        logic [31:0] q0;
        logic [31:0] r0;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; dividend = a; divisor = b;
        lat = -1; stall = 0; moved = 1'b0; q = '0; r = '0;
        #1;
        q0 = quotient;
        r0 = remainder;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (stallreq_for_div === 1'b1) stall++;
            if (ready === 1'b1) begin
                lat = c;
                q = quotient;
                r = remainder;
                break;
            end
            if (quotient !== q0 || remainder !== r0) moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder got %h want 0", remainder); end
        n_cmp++; if (stallreq_for_div !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stallreq_for_div); end
        rst = 1'b1;
        last_q = '0; last_r = '0;
    endtask

    task automatic test_divu_basic();
        int lat, stall, rc0;
        logic [31:0] q, r;
        bit moved;
        exp_t e;
        exp_q.push_back('{q: 32'd14, r: 32'd2});
        rc0 = ready_cnt;
        do_op(32'd100, 32'd7, 1'b0, lat, stall, q, r, moved);
        n_cmp++; if (stallreq_for_div !== 1'b0) begin n_fail++; $display("FAIL divu_stall_at_done got %b want 0", stallreq_for_div); end
        start = 1'b0;
        repeat (5) @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", lat); end
        n_cmp++; if (stall !== 33) begin n_fail++; $display("FAIL divu_stall_cycles got %0d want 33", stall); end
        n_cmp++; if (q !== e.q) begin n_fail++; $display("FAIL divu_quotient got %h want %h", q, e.q); end
        n_cmp++; if (r !== e.r) begin n_fail++; $display("FAIL divu_remainder got %h want %h", r, e.r); end
        n_cmp++; if (ready_cnt - rc0 !== 1) begin n_fail++; $display("FAIL divu_ready_pulses got %0d want 1", ready_cnt - rc0); end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_signed();
        logic [31:0] a_t[3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] b_t[3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] q_t[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] r_t[3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        int lat, stall;
        logic [31:0] q, r;
        bit moved;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{q: q_t[i], r: r_t[i]});
            do_op(a_t[i], b_t[i], 1'b1, lat, stall, q, r, moved);
            start = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency[%0d] got %0d want 33", i, lat); end
            n_cmp++; if (q !== e.q) begin n_fail++; $display("FAIL div_quotient[%0d] got %h want %h", i, q, e.q); end
            n_cmp++; if (r !== e.r) begin n_fail++; $display("FAIL div_remainder[%0d] got %h want %h", i, r, e.r); end
            last_q = e.q; last_r = e.r;
        end
    endtask

    task automatic test_divu_edges();
        int lat, stall;
        logic [31:0] q, r;
        bit moved;
        exp_t e;
        exp_q.push_back('{q: 32'hFFFF_FFFF, r: 32'h1234_5678});
        do_op(32'h1234_5678, 32'd0, 1'b0, lat, stall, q, r, moved);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL zero_latency got %0d want 2", lat); end
        n_cmp++; if (stall !== 2) begin n_fail++; $display("FAIL zero_stall_cycles got %0d want 2", stall); end
        n_cmp++; if (q !== e.q) begin n_fail++; $display("FAIL zero_quotient got %h want %h", q, e.q); end
        n_cmp++; if (r !== e.r) begin n_fail++; $display("FAIL zero_remainder got %h want %h", r, e.r); end
        exp_q.push_back('{q: 32'hFFFF_FFFF, r: 32'd0});
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, stall, q, r, moved);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (q !== e.q) begin n_fail++; $display("FAIL divu_max_quotient got %h want %h", q, e.q); end
        n_cmp++; if (r !== e.r) begin n_fail++; $display("FAIL divu_max_remainder got %h want %h", r, e.r); end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_annul();
        int rc0;
        bit seen_stall_drop;
        rc0 = ready_cnt;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1;
        n_cmp++; if (stallreq_for_div !== 1'b0) begin n_fail++; $display("FAIL annul_stall got %b want 0", stallreq_for_div); end
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        #1;
        n_cmp++; if (stallreq_for_div !== 1'b0) begin n_fail++; $display("FAIL annul_idle_stall got %b want 0", stallreq_for_div); end
        seen_stall_drop = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (stallreq_for_div !== 1'b0) seen_stall_drop = 1'b1;
        end
        n_cmp++; if (seen_stall_drop) begin n_fail++; $display("FAIL annul_still_running got 1 want 0"); end
        n_cmp++; if (ready_cnt - rc0 !== 0) begin n_fail++; $display("FAIL annul_ready_pulses got %0d want 0", ready_cnt - rc0); end
        n_cmp++; if (quotient !== last_q) begin n_fail++; $display("FAIL annul_quotient_held got %h want %h", quotient, last_q); end
        n_cmp++; if (remainder !== last_r) begin n_fail++; $display("FAIL annul_remainder_held got %h want %h", remainder, last_r); end
    endtask

    task automatic test_reset_mid();
        int rc0;
        rc0 = ready_cnt;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd500; divisor = 32'd9;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        #1;
        n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL rstmid_quotient got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL rstmid_remainder got %h want 0", remainder); end
        n_cmp++; if (stallreq_for_div !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b want 0", stallreq_for_div); end
        repeat (40) @(negedge clk);
        n_cmp++; if (ready_cnt - rc0 !== 0) begin n_fail++; $display("FAIL rstmid_ready_pulses got %0d want 0", ready_cnt - rc0); end
        last_q = '0; last_r = '0;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, stall;
        logic [31:0] q, r;
        bit moved;
        exp_t e;
        exp_q.push_back('{q: 32'd14, r: 32'd2});
        exp_q.push_back('{q: 32'd3, r: 32'd0});
        do_op(32'd100, 32'd7, 1'b0, lat1, stall, q, r, moved);
        e = exp_q.pop_front();
        n_cmp++; if (lat1 !== 33) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 33", lat1); end
        n_cmp++; if (q !== e.q || r !== e.r) begin n_fail++; $display("FAIL b2b_first_result got %h/%h want %h/%h", q, r, e.q, e.r); end
        do_op(32'd9, 32'd3, 1'b0, lat2, stall, q, r, moved);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (lat2 + 1 !== 34) begin n_fail++; $display("FAIL b2b_gap got %0d want 34", lat2 + 1); end
        n_cmp++; if (moved) begin n_fail++; $display("FAIL b2b_first_stable got changed want held"); end
        n_cmp++; if (q !== e.q) begin n_fail++; $display("FAIL b2b_quotient got %h want %h", q, e.q); end
        n_cmp++; if (r !== e.r) begin n_fail++; $display("FAIL b2b_remainder got %h want %h", r, e.r); end
        last_q = e.q; last_r = e.r;
    endtask

    task automatic test_random();
        int lat, stall;
        logic [31:0] a, b, eq, er, q, r;
        logic sgn;
        bit moved;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = (i % 3 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            sgn = 1'(i % 2);
            if (i == 4) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 14));
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'd5;
            ref_div(a, b, sgn, eq, er);
            exp_q.push_back('{q: eq, r: er});
            do_op(a, b, sgn, lat, stall, q, r, moved);
            start = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if (q !== e.q || r !== e.r || lat !== 33) begin
                n_fail++;
                $display("FAIL rand[%0d] %h/%h sgn=%b got q=%h r=%h lat=%0d want q=%h r=%h lat=33",
                         i, a, b, sgn, q, r, lat, e.q, e.r);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; ready_cnt = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_divu_edges();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
